hms_time_counter: RTL and testbench

Time-of-day counter for the seconds clock. It consumes the slow square-wave output of the clock-divider chain, which is a level signal and not a pulse, and resynchronises it into the system clock domain. It converts each rising edge into a one-cycle tick and keeps a BCD hh:mm:ss count with a validated parallel-load port for setting the time. It sits between the divider chain and the seven-segment display driver.

---
 rtl/hms_time_counter.sv | 102 ++++++++++
 tb/tb_hms_time_counter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hms_time_counter.sv
// BCD hh:mm:ss time-of-day counter driven by the divided seconds clock.
// slow_in is resynchronised, edge-detected, prescaled, and advances the time; loads are range-checked.
module hms_time_counter #(
   parameter int TICKS_PER_SEC = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       slow_in,
   input  logic       run,
   input  logic       load,
   input  logic [7:0] load_hh,
   input  logic [7:0] load_mm,
   input  logic [7:0] load_ss,
   output logic [7:0] hh,
   output logic [7:0] mm,
   output logic [7:0] ss,
   output logic       sec_pulse,
   output logic       rollover,
   output logic       load_err
);

   localparam logic [7:0] PMAX = 8'(TICKS_PER_SEC - 1);

   logic       s1, s2, s3;
   logic       rise;
   logic [7:0] pcnt;
   logic       load_ok;
   logic       ss_wrap, mm_wrap, day_wrap;
   logic [7:0] ss_n, mm_n, hh_n;

   function automatic logic [7:0] inc60(input logic [7:0] v);
      if (v == 8'h59)         return 8'h00;
      else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      else                    return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] inc24(input logic [7:0] v);
      if (v == 8'h23)         return 8'h00;
      else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      else                    return {v[7:4], v[3:0] + 4'd1};
   endfunction

   assign rise = s2 & ~s3;

   assign load_ok = (load_ss[3:0] <= 4'd9) && (load_ss[7:4] <= 4'd5) &&
                    (load_mm[3:0] <= 4'd9) && (load_mm[7:4] <= 4'd5) &&
                    (load_hh[3:0] <= 4'd9) && (load_hh[7:4] <= 4'd2) &&
                    ((load_hh[7:4] != 4'd2) || (load_hh[3:0] <= 4'd3));

   // Carries ripple combinationally so every digit lands on the same edge.
   assign ss_wrap  = (ss == 8'h59);
   assign mm_wrap  = (mm == 8'h59);
   assign day_wrap = ss_wrap & mm_wrap & (hh == 8'h23);
   assign ss_n     = inc60(ss);
   assign mm_n     = ss_wrap ? inc60(mm) : mm;
   assign hh_n     = (ss_wrap & mm_wrap) ? inc24(hh) : hh;

   always_ff @(posedge clk) begin
      if (reset) begin
         // Synchroniser resets high so a level already high at release is not an edge.
         s1        <= 1'b1;
         s2        <= 1'b1;
         s3        <= 1'b1;
         pcnt      <= 8'd0;
         hh        <= 8'h00;
         mm        <= 8'h00;
         ss        <= 8'h00;
         sec_pulse <= 1'b0;
         rollover  <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         s1        <= slow_in;
         s2        <= s1;
         s3        <= s2;
         sec_pulse <= 1'b0;
         rollover  <= 1'b0;
         load_err  <= 1'b0;
         if (load) begin
            if (load_ok) begin
               hh   <= load_hh;
               mm   <= load_mm;
               ss   <= load_ss;
               pcnt <= 8'd0;
            end else begin
               load_err <= 1'b1;
            end
         end else if (rise && run) begin
            if (pcnt == PMAX) begin
               pcnt      <= 8'd0;
               ss        <= ss_n;
               mm        <= mm_n;
               hh        <= hh_n;
               sec_pulse <= 1'b1;
               rollover  <= day_wrap;
            end else begin
               pcnt <= pcnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hms_time_counter.sv
// Scoreboarded bench: two instances (1 and 5 ticks/sec) share stimulus; a seconds-of-day model predicts events.
module tb_hms_time_counter;

   logic       clk = 1'b0;
   logic       reset, slow_in, run, load;
   logic [7:0] load_hh, load_mm, load_ss;
   logic [7:0] hh1, mm1, ss1, hh5, mm5, ss5;
   logic       sp1, ro1, le1, sp5, ro5, le5;

   hms_time_counter #(.TICKS_PER_SEC(1)) u_dut1 (
      .clk(clk), .reset(reset), .slow_in(slow_in), .run(run), .load(load),
      .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
      .hh(hh1), .mm(mm1), .ss(ss1), .sec_pulse(sp1), .rollover(ro1), .load_err(le1));

   hms_time_counter #(.TICKS_PER_SEC(5)) u_dut5 (
      .clk(clk), .reset(reset), .slow_in(slow_in), .run(run), .load(load),
      .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
      .hh(hh5), .mm(mm5), .ss(ss5), .sec_pulse(sp5), .rollover(ro5), .load_err(le5));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] hh, mm, ss;
      bit         sp, ro, le;
      int         cyc;
   } exp_t;

   exp_t q1[$];
   exp_t q5[$];
   int   nchk  = 0;
   int   npass = 0;
   int   tsec[2];
   int   pc[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [7:0] bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [23:0] hms(input int t);
      return {bcd(t / 3600), bcd((t / 60) % 60), bcd(t % 60)};
   endfunction

   function automatic int tps(input int k);
      return (k == 0) ? 1 : 5;
   endfunction

   task automatic push(input int k, input exp_t e);
      if (k == 0) q1.push_back(e);
      else        q5.push_back(e);
   endtask

   // Rise reaching the prescaler; outputs for it are due at edge c.
   task automatic model_rise(input int c);
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         if (run) begin
            pc[k]++;
            if (pc[k] == tps(k)) begin
               pc[k]   = 0;
               tsec[k] = (tsec[k] + 1) % 86400;
               {e.hh, e.mm, e.ss} = hms(tsec[k]);
               e.sp  = 1'b1;
               e.ro  = (tsec[k] == 0);
               e.le  = 1'b0;
               e.cyc = c;
               push(k, e);
            end
         end
      end
   endtask

   task automatic check_time(input string nm);
      chk({nm, "_t1"}, {8'h00, hh1, mm1, ss1}, {8'h00, hms(tsec[0])});
      chk({nm, "_t5"}, {8'h00, hh5, mm5, ss5}, {8'h00, hms(tsec[1])});
   endtask

   task automatic tick();
      @(negedge clk);
      slow_in = 1'b1;
      model_rise(cyc + 3);
      repeat (5) @(negedge clk);
      slow_in = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input bit coinc);
      int   hv, mv, sv;
      bit   ok;
      exp_t e;
      hv = h[7:4] * 10 + h[3:0];
      mv = m[7:4] * 10 + m[3:0];
      sv = s[7:4] * 10 + s[3:0];
      ok = (h[3:0] <= 9) && (m[3:0] <= 9) && (s[3:0] <= 9) &&
           (h[7:4] <= 9) && (m[7:4] <= 9) && (s[7:4] <= 9) &&
           (hv < 24) && (mv < 60) && (sv < 60);
      @(negedge clk);
      if (coinc) begin
         slow_in = 1'b1;
         @(negedge clk);
         @(negedge clk);
      end
      load = 1'b1; load_hh = h; load_mm = m; load_ss = s;
      if (!ok) begin
         for (int k = 0; k < 2; k++) begin
            {e.hh, e.mm, e.ss} = hms(tsec[k]);
            e.sp = 1'b0; e.ro = 1'b0; e.le = 1'b1; e.cyc = cyc + 1;
            push(k, e);
         end
      end
      @(negedge clk);
      load = 1'b0;
      if (ok) begin
         for (int k = 0; k < 2; k++) begin
            tsec[k] = hv * 3600 + mv * 60 + sv;
            pc[k]   = 0;
         end
         check_time("load");
         chk("load_ok_err", {30'd0, le1, le5}, 32'd0);
      end
      if (coinc) begin
         repeat (3) @(negedge clk);
         slow_in = 1'b0;
         repeat (5) @(negedge clk);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("reset_d1", {hh1, mm1, ss1, 5'd0, sp1, ro1, le1}, 32'd0);
      chk("reset_d5", {hh5, mm5, ss5, 5'd0, sp5, ro5, le5}, 32'd0);
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tsec[k] = 0;
         pc[k]   = 0;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sp1 || ro1 || le1) begin
         if (q1.size() == 0) begin
            nchk++;
            $display("FAIL d1_unexpected: got sp=%b ro=%b le=%b at %h:%h:%h, expected no event", sp1, ro1, le1, hh1, mm1, ss1);
         end else begin
            e = q1.pop_front();
            chk("d1_event", {hh1, mm1, ss1, 5'd0, sp1, ro1, le1}, {e.hh, e.mm, e.ss, 5'd0, e.sp, e.ro, e.le});
            chk("d1_latency", cyc, e.cyc);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (sp5 || ro5 || le5) begin
         if (q5.size() == 0) begin
            nchk++;
            $display("FAIL d5_unexpected: got sp=%b ro=%b le=%b at %h:%h:%h, expected no event", sp5, ro5, le5, hh5, mm5, ss5);
         end else begin
            e = q5.pop_front();
            chk("d5_event", {hh5, mm5, ss5, 5'd0, sp5, ro5, le5}, {e.hh, e.mm, e.ss, 5'd0, e.sp, e.ro, e.le});
            chk("d5_latency", cyc, e.cyc);
         end
      end
   end

   initial begin
      logic [7:0] h, m, s;
      int         r;
      reset = 1'b1; slow_in = 1'b1; run = 1'b1; load = 1'b0;
      load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;
      for (int k = 0; k < 2; k++) begin tsec[k] = 0; pc[k] = 0; end
      repeat (3) @(negedge clk);
      chk("reset_state", {hh1, mm1, ss1, 5'd0, sp1, ro1, le1}, 32'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check_time("post_reset_high");
      slow_in = 1'b0;
      repeat (3) @(negedge clk);

      repeat (3) tick();
      chk("three_ticks_ss", {24'd0, ss1}, 32'h03);

      do_load(8'h23, 8'h59, 8'h58, 1'b0);
      tick();
      tick();
      chk("midnight_wrap", {8'h00, hh1, mm1, ss1}, 32'h0);

      do_load(8'h24, 8'h00, 8'h00, 1'b0);
      do_load(8'h12, 8'h60, 8'h00, 1'b0);
      do_load(8'h0A, 8'h00, 8'h00, 1'b0);
      check_time("after_bad_loads");
      do_load(8'h09, 8'h59, 8'h59, 1'b0);

      do_load(8'h00, 8'h00, 8'h00, 1'b0);
      repeat (4) tick();
      do_load(8'h10, 8'h00, 8'h00, 1'b1);
      chk("coinc_load_d5", {8'h00, hh5, mm5, ss5}, 32'h00100000);
      repeat (5) tick();
      chk("five_more_d5", {8'h00, hh5, mm5, ss5}, 32'h00100001);
      run = 1'b0;
      repeat (7) tick();
      run = 1'b1;
      check_time("run_low_hold");

      do_load(8'h05, 8'h06, 8'h07, 1'b0);
      repeat (3) tick();
      do_reset();
      repeat (4) tick();
      chk("post_reset_partial_d5", {8'h00, hh5, mm5, ss5}, 32'h0);
      tick();
      chk("post_reset_full_d5", {8'h00, hh5, mm5, ss5}, 32'h00000001);

      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         if (r <= 5) begin
            run = ($urandom_range(0, 3) != 0);
            tick();
         end else if (r <= 8) begin
            h = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
            m = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            s = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 3) == 0) m[7:4] = 4'($urandom_range(6, 15));
            if ($urandom_range(0, 3) == 0) s[3:0] = 4'($urandom_range(10, 15));
            do_load(h, m, s, r == 8);
         end else begin
            do_load(8'h23, 8'h59, {4'd5, 4'($urandom_range(5, 9))}, 1'b0);
         end
      end
      run = 1'b1;
      check_time("random_end");

      repeat (20) @(negedge clk);
      chk("q1_drained", q1.size(), 32'd0);
      chk("q5_drained", q5.size(), 32'd0);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
